// File: rtl/tof_i2c_cmd_sequencer.sv
// Command sequencer in front of the ToF I2C transaction engine: queues register
// read/write commands, issues them one at a time and returns one in-order response each.
module tof_i2c_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h29
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_read,
  input  logic [15:0] cmd_reg_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        cmd_two_bytes,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,
  output logic [6:0]  i2c_slave_address,
  output logic [15:0] i2c_register_address,
  output logic [7:0]  i2c_data_in,
  output logic        i2c_is_read,
  output logic [9:0]  i2c_nb_of_bytes,
  output logic        i2c_start,
  output logic        i2c_reset,
  input  logic        i2c_ready,
  input  logic [15:0] i2c_data_out,
  input  logic        i2c_error
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ENTRY_W = 26;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_RESPOND, S_RECOVER} state_e;

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               ready_prev_q;
  logic [15:0]        result_q, result_d;
  logic               result_err_q, result_err_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_data_q, rsp_data_d;
  logic               rsp_error_q, rsp_error_d;
  logic               busy_q, busy_d;
  logic [15:0]        reg_addr_q, reg_addr_d;
  logic [7:0]         data_in_q, data_in_d;
  logic               is_read_q, is_read_d;
  logic [9:0]         nb_q, nb_d;
  logic               start_q, start_d;
  logic               eng_reset_q, eng_reset_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] head;

  assign push = cmd_valid && cmd_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);
  assign head = fifo_mem_q[rd_ptr_q];

  // Two-byte length is only meaningful for reads, so it is cleared on entry.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_is_read, cmd_two_bytes & cmd_is_read, cmd_reg_addr, cmd_wdata};
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    tmo_d        = tmo_q;
    result_d     = result_q;
    result_err_d = result_err_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;
    reg_addr_d   = reg_addr_q;
    data_in_d    = data_in_q;
    is_read_d    = is_read_q;
    nb_d         = nb_q;
    start_d      = 1'b0;
    eng_reset_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d    = S_ISSUE;
          is_read_d  = head[25];
          nb_d       = head[24] ? 10'd2 : 10'd1;
          reg_addr_d = head[23:8];
          data_in_d  = head[7:0];
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_q + TMO_W'(1);
        // Completion takes priority over a coincident timeout.
        if (i2c_ready && !ready_prev_q) begin
          state_d      = S_RESPOND;
          result_err_d = i2c_error;
          if (!is_read_q) begin
            result_d = 16'h0000;
          end else if (nb_q == 10'd2) begin
            result_d = i2c_data_out;
          end else begin
            result_d = {8'h00, i2c_data_out[7:0]};
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d      = S_RECOVER;
          tmo_d        = '0;
          result_d     = 16'hFFFF;
          result_err_d = 1'b1;
        end
      end
      S_RECOVER: begin
        eng_reset_d = 1'b1;
        tmo_d       = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_W'(1)) begin
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = result_q;
        rsp_error_d = result_err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (count_d != FULL_CNT);
    busy_d      = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tmo_q        <= '0;
      ready_prev_q <= 1'b1;
      result_q     <= '0;
      result_err_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      reg_addr_q   <= '0;
      data_in_q    <= '0;
      is_read_q    <= 1'b0;
      nb_q         <= 10'd1;
      start_q      <= 1'b0;
      eng_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tmo_q        <= tmo_d;
      ready_prev_q <= i2c_ready;
      result_q     <= result_d;
      result_err_q <= result_err_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
      busy_q       <= busy_d;
      reg_addr_q   <= reg_addr_d;
      data_in_q    <= data_in_d;
      is_read_q    <= is_read_d;
      nb_q         <= nb_d;
      start_q      <= start_d;
      eng_reset_q  <= eng_reset_d;
    end
  end

  assign cmd_ready            = cmd_ready_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_data             = rsp_data_q;
  assign rsp_error            = rsp_error_q;
  assign busy                 = busy_q;
  assign i2c_slave_address    = SLAVE_ADDR;
  assign i2c_register_address = reg_addr_q;
  assign i2c_data_in          = data_in_q;
  assign i2c_is_read          = is_read_q;
  assign i2c_nb_of_bytes      = nb_q;
  assign i2c_start            = start_q;
  assign i2c_reset            = eng_reset_q;

endmodule

// File: tb/tb_tof_i2c_cmd_sequencer.sv
// Randomized bench for tof_i2c_cmd_sequencer with a small engine model and a
// response reference model derived from the command and engine outcome.
module tb_tof_i2c_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_is_read = 1'b0;
  logic [15:0] cmd_reg_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        cmd_two_bytes = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic [6:0]  i2c_slave_address;
  logic [15:0] i2c_register_address;
  logic [7:0]  i2c_data_in;
  logic        i2c_is_read;
  logic [9:0]  i2c_nb_of_bytes;
  logic        i2c_start;
  logic        i2c_reset;
  logic        i2c_ready = 1'b0;
  logic [15:0] i2c_data_out = '0;
  logic        i2c_error = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  tof_i2c_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SLAVE_ADDR(7'h29)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_read(cmd_is_read),
    .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata), .cmd_two_bytes(cmd_two_bytes),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
    .i2c_slave_address(i2c_slave_address), .i2c_register_address(i2c_register_address),
    .i2c_data_in(i2c_data_in), .i2c_is_read(i2c_is_read), .i2c_nb_of_bytes(i2c_nb_of_bytes),
    .i2c_start(i2c_start), .i2c_reset(i2c_reset), .i2c_ready(i2c_ready),
    .i2c_data_out(i2c_data_out), .i2c_error(i2c_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: what a response must carry, given the command and what the engine returned.
  function automatic logic [15:0] exp_data(input logic rd, input logic two, input logic [15:0] eng);
    if (!rd) return 16'h0000;
    if (two) return eng;
    return {8'h00, eng[7:0]};
  endfunction

  function automatic logic [9:0] exp_nb(input logic rd, input logic two);
    return (rd && two) ? 10'd2 : 10'd1;
  endfunction

  task automatic push_cmd(input logic rd, input logic [15:0] addr, input logic [7:0] wd,
                          input logic two, output int acc, output bit ok);
    int n;
    n = 0;
    @(negedge clock);
    cmd_is_read = rd; cmd_reg_addr = addr; cmd_wdata = wd; cmd_two_bytes = two; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok  = (cmd_ready === 1'b1);
    acc = cyc + 1;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int scyc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clock);
      if (i2c_start === 1'b1) ok = 1'b1;
    end
    scyc = cyc;
  endtask

  task automatic engine_done(input int dly, input logic [15:0] d, input logic e, output int k);
    repeat (dly) @(negedge clock);
    i2c_data_out = d; i2c_error = e; i2c_ready = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    i2c_ready = 1'b0;
  endtask

  task automatic wait_rsp(output logic [15:0] d, output logic e, output int r, output bit ok);
    ok = 1'b0; d = '0; e = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1; d = rsp_data; e = rsp_error;
      end
    end
    r = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (i2c_reset !== 1'b1) begin errors++; $display("FAIL reset_i2c_reset got %0b want 1", i2c_reset); end
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL reset_i2c_start got %0b want 0", i2c_start); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", rsp_data); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got %0b want 0", rsp_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (i2c_register_address !== 16'h0) begin errors++; $display("FAIL reset_reg_addr got %h want 0000", i2c_register_address); end
    checks++; if (i2c_data_in !== 8'h0 || i2c_is_read !== 1'b0) begin errors++; $display("FAIL reset_data_dir got %h/%0b want 00/0", i2c_data_in, i2c_is_read); end
    checks++; if (i2c_nb_of_bytes !== 10'd1) begin errors++; $display("FAIL reset_nb got %0d want 1", i2c_nb_of_bytes); end
    checks++; if (i2c_slave_address !== 7'h29) begin errors++; $display("FAIL slave_addr got %h want 29", i2c_slave_address); end
    checks++; if (i2c_reset !== 1'b0) begin errors++; $display("FAIL post_reset_i2c_reset got %0b want 0", i2c_reset); end
  endtask

  task automatic test_write();
    int acc, s, k, r; bit ok; logic [15:0] d; logic e;
    push_cmd(1'b0, 16'h0087, 8'h01, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_accept got 0 want 1"); end
    wait_start(s, ok);
    checks++; if (!ok || s != acc + 2) begin errors++; $display("FAIL write_start_latency got %0d want %0d", s - acc, 2); end
    checks++; if (i2c_is_read !== 1'b0 || i2c_nb_of_bytes !== 10'd1) begin errors++; $display("FAIL write_dir_nb got %0b/%0d want 0/1", i2c_is_read, i2c_nb_of_bytes); end
    checks++; if (i2c_register_address !== 16'h0087 || i2c_data_in !== 8'h01) begin errors++; $display("FAIL write_fields got %h/%h want 0087/01", i2c_register_address, i2c_data_in); end
    engine_done(40, 16'h5A5A, 1'b0, k);
    wait_rsp(d, e, r, ok);
    checks++; if (!ok || r != k + 1) begin errors++; $display("FAIL write_rsp_timing got %0d want %0d", r, k + 1); end
    checks++; if (d !== 16'h0000 || e !== 1'b0) begin errors++; $display("FAIL write_rsp got %h/%0b want 0000/0", d, e); end
    $display("write reg 0087 -> rsp %h err %0b", d, e);
  endtask

  task automatic test_read();
    logic [15:0] engv [2];
    logic [15:0] expv [2];
    logic        twov [2];
    int acc, s, k, r; bit ok; logic [15:0] d; logic e;
    engv[0] = 16'hEACC; expv[0] = 16'hEACC; twov[0] = 1'b1;
    engv[1] = 16'h12AB; expv[1] = 16'h00AB; twov[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_cmd(1'b1, 16'h010F, 8'h00, twov[i], acc, ok);
      wait_start(s, ok);
      checks++; if (!ok || i2c_is_read !== 1'b1 || i2c_nb_of_bytes !== (twov[i] ? 10'd2 : 10'd1)) begin
        errors++; $display("FAIL read_issue got %0b/%0d want 1/%0d", i2c_is_read, i2c_nb_of_bytes, twov[i] ? 2 : 1);
      end
      engine_done(5, engv[i], 1'b0, k);
      wait_rsp(d, e, r, ok);
      checks++; if (!ok || d !== expv[i] || e !== 1'b0) begin errors++; $display("FAIL read_rsp got %h/%0b want %h/0", d, e, expv[i]); end
      $display("read reg 010F two=%0b -> rsp %h", twov[i], d);
    end
  endtask

  task automatic test_fifo_full();
    logic        rdq [16];
    logic        twq [16];
    logic [15:0] adq [16];
    int nacc, s, k, r, extra; bit ok; logic [15:0] d, eng; logic e;
    for (int i = 0; i < 16; i++) begin
      rdq[i] = 1'($urandom_range(0, 1)); twq[i] = 1'($urandom_range(0, 1)); adq[i] = 16'($urandom);
    end
    nacc = 0;
    @(negedge clock);
    for (int c = 0; c < 12; c++) begin
      cmd_is_read = rdq[nacc]; cmd_two_bytes = twq[nacc]; cmd_reg_addr = adq[nacc];
      cmd_wdata = 8'($urandom); cmd_valid = 1'b1;
      if (cmd_ready === 1'b1) nacc++;
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    checks++; if (nacc != DEPTH + 1) begin errors++; $display("FAIL fifo_accepted got %0d want %0d", nacc, DEPTH + 1); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %0b want 0", cmd_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fifo_busy got %0b want 1", busy); end
    for (int i = 0; i < nacc; i++) begin
      ok = 1'b1;
      if (i > 0) wait_start(s, ok);
      checks++; if (!ok || i2c_register_address !== adq[i]) begin errors++; $display("FAIL fifo_order idx %0d got %h want %h", i, i2c_register_address, adq[i]); end
      eng = 16'($urandom);
      engine_done(2, eng, 1'b0, k);
      wait_rsp(d, e, r, ok);
      checks++; if (!ok || d !== exp_data(rdq[i], twq[i], eng) || e !== 1'b0) begin
        errors++; $display("FAIL fifo_rsp idx %0d got %h/%0b want %h/0", i, d, e, exp_data(rdq[i], twq[i], eng));
      end
      $display("fifo cmd %0d reg %h -> rsp %h", i, adq[i], d);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL fifo_extra_rsp got %0d want 0", extra); end
  endtask

  task automatic test_timeout();
    int acc, s, k, r, rst_cnt; bit ok, got; logic [15:0] d, eng; logic e;
    push_cmd(1'b1, 16'h0200, 8'h00, 1'b1, acc, ok);
    wait_start(s, ok);
    push_cmd(1'b0, 16'h0301, 8'h7E, 1'b0, acc, ok);
    rst_cnt = 0; got = 1'b0; r = 0; d = '0; e = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clock);
      if (i2c_reset === 1'b1) rst_cnt++;
      if (rsp_valid === 1'b1) begin got = 1'b1; r = cyc; d = rsp_data; e = rsp_error; end
    end
    checks++; if (rst_cnt != 2) begin errors++; $display("FAIL timeout_reset_len got %0d want 2", rst_cnt); end
    checks++; if (!got || r != s + TMO + 3) begin errors++; $display("FAIL timeout_rsp_timing got %0d want %0d", r - s, TMO + 3); end
    checks++; if (d !== 16'hFFFF || e !== 1'b1) begin errors++; $display("FAIL timeout_rsp got %h/%0b want FFFF/1", d, e); end
    $display("timeout -> rsp %h err %0b after %0d cycles", d, e, r - s);
    wait_start(s, ok);
    checks++; if (!ok || i2c_register_address !== 16'h0301 || i2c_is_read !== 1'b0) begin errors++; $display("FAIL timeout_next_issue got %h/%0b want 0301/0", i2c_register_address, i2c_is_read); end
    eng = 16'($urandom);
    engine_done(5, eng, 1'b0, k);
    wait_rsp(d, e, r, ok);
    checks++; if (!ok || d !== 16'h0000 || e !== 1'b0) begin errors++; $display("FAIL timeout_next_rsp got %h/%0b want 0000/0", d, e); end
  endtask

  task automatic test_error();
    int acc, s, k, r; bit ok; logic [15:0] d, eng; logic e;
    eng = 16'($urandom);
    push_cmd(1'b1, 16'h0044, 8'h00, 1'b1, acc, ok);
    wait_start(s, ok);
    engine_done(7, eng, 1'b1, k);
    i2c_error = 1'b0;
    wait_rsp(d, e, r, ok);
    checks++; if (!ok || e !== 1'b1 || d !== eng) begin errors++; $display("FAIL error_rsp got %h/%0b want %h/1", d, e, eng); end
    $display("error read -> rsp %h err %0b", d, e);
  endtask

  task automatic test_reset_mid();
    int acc, s, k, nrsp, nstart; bit ok;
    push_cmd(1'b1, 16'h0500, 8'h00, 1'b0, acc, ok);
    wait_start(s, ok);
    push_cmd(1'b0, 16'h0501, 8'h11, 1'b0, acc, ok);
    push_cmd(1'b0, 16'h0502, 8'h22, 1'b0, acc, ok);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (i2c_reset !== 1'b1) begin errors++; $display("FAIL midreset_i2c_reset got %0b want 1", i2c_reset); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_state got busy %0b ready %0b want 0/1", busy, cmd_ready); end
    engine_done(3, 16'hBEEF, 1'b0, k);
    nrsp = 0; nstart = 0;
    repeat (30) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) nrsp++;
      if (i2c_start === 1'b1) nstart++;
    end
    checks++; if (nrsp != 0 || nstart != 0) begin errors++; $display("FAIL midreset_activity got rsp %0d start %0d want 0/0", nrsp, nstart); end
    $display("reset mid-transaction -> rsp %0d start %0d", nrsp, nstart);
  endtask

  task automatic test_back_to_back();
    logic        rdq [4];
    logic        twq [4];
    logic [15:0] adq [4];
    logic [7:0]  wdq [4];
    int acc, s0, s, k, r, prev_r; bit ok; logic [15:0] d, eng; logic e, eerr;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 4; i++) begin
        rdq[i] = 1'($urandom_range(0, 1)); twq[i] = 1'($urandom_range(0, 1));
        adq[i] = 16'($urandom); wdq[i] = 8'($urandom);
      end
      push_cmd(rdq[0], adq[0], wdq[0], twq[0], acc, ok);
      wait_start(s0, ok);
      for (int i = 1; i < 4; i++) push_cmd(rdq[i], adq[i], wdq[i], twq[i], acc, ok);
      prev_r = 0;
      for (int i = 0; i < 4; i++) begin
        ok = 1'b1; s = s0;
        if (i > 0) begin
          wait_start(s, ok);
          checks++; if (!ok || s - prev_r < 2) begin errors++; $display("FAIL b2b_gap got %0d want >=2", s - prev_r); end
        end
        checks++; if (i2c_register_address !== adq[i] || i2c_is_read !== rdq[i] || i2c_nb_of_bytes !== exp_nb(rdq[i], twq[i])
                      || (!rdq[i] && i2c_data_in !== wdq[i])) begin
          errors++; $display("FAIL b2b_issue got %h/%0b/%0d/%h want %h/%0b/%0d/%h", i2c_register_address, i2c_is_read,
                             i2c_nb_of_bytes, i2c_data_in, adq[i], rdq[i], exp_nb(rdq[i], twq[i]), wdq[i]);
        end
        eng = 16'($urandom); eerr = 1'($urandom_range(0, 1));
        engine_done($urandom_range(1, 12), eng, eerr, k);
        i2c_error = 1'b0;
        wait_rsp(d, e, r, ok);
        checks++; if (!ok || r != k + 1 || d !== exp_data(rdq[i], twq[i], eng) || e !== eerr) begin
          errors++; $display("FAIL b2b_rsp got %h/%0b at %0d want %h/%0b at %0d", d, e, r, exp_data(rdq[i], twq[i], eng), eerr, k + 1);
        end
        $display("b2b round %0d cmd %0d rd=%0b reg %h -> rsp %h err %0b", round, i, rdq[i], adq[i], d, e);
        prev_r = r;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_timeout();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
